dac_tx: RTL and testbench
=========================

Name: dac_tx

Overview:
- Transmit-side counterpart of the ADC capture path: takes 8-bit samples over a valid/ready stream and drives a parallel DAC bus.
- Buffers samples in a small FIFO and pops one sample per programmable update period.
- Generates a source-synchronous DAC latch clock, plus a built-in ramp pattern mode for bring-up.
- Sits between sample producers (counters, capture logic) and the DAC output pins.

Parameters:
- DATA_W, 8, sample width.
- DEPTH, 8, FIFO depth in entries; power of 2, minimum 2.
- DIV_W, 8, width of the rate divider input.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  transmit enable.
- div  in  DIV_W  update period control; effective period P = max(div,1)+1 clk cycles.
- pattern_mode  in  1  0 = FIFO data, 1 = internal ramp.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a sample (= not full).
- dac_data  out  DATA_W  registered DAC data bus.
- dac_clk  out  1  DAC latch clock; DAC samples on rising edge.
- dac_strobe  out  1  one-cycle pulse in the first cycle a new dac_data value is driven.
- underflow  out  1  sticky: an update found the FIFO empty.
- clr_underflow  in  1  clears underflow.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - dac_data=0, dac_clk=0, dac_strobe=0, underflow=0, fifo_level=0, s_ready=1.
  - Internal state cleared: tick_cnt=0, ramp=0, FIFO pointers=0, d_q=1.
- Divider:
  - d_q = max(div,1) is latched when tick_cnt==d_q (wrap) or while en=0. A div change therefore takes effect only at a period boundary.
  - tick_cnt counts 0..d_q and wraps to 0 while en=1. While en=0 it is held at 0.
  - The update event occurs on the cycle tick_cnt==d_q with en=1.
- Update event, registered; the results below are visible the next cycle:
  - pattern_mode=1: dac_data<=ramp, ramp<=ramp+1 modulo 2^DATA_W (FF wraps to 00). FIFO is not popped.
  - pattern_mode=0 and FIFO not empty: pop the head into dac_data.
  - pattern_mode=0 and FIFO empty: dac_data holds its value and underflow<=1.
  - dac_strobe<=1 on every update event, including underflow and hold; 0 otherwise.
- dac_clk:
  - Set to 0 on the update event.
  - Set to 1 on the cycle tick_cnt==(d_q>>1) with en=1.
  - The rising edge therefore lands mid-period, after the new data has been stable for at least 1 cycle.
  - While en=0, dac_clk is driven to 0 and dac_data holds.
- FIFO:
  - A push occurs when s_valid && s_ready. s_ready is 0 exactly when level==DEPTH.
  - A pop happens only on an update event.
  - Simultaneous push and pop: level is unchanged; a push while full is impossible.
  - Push into an empty FIFO on the same cycle as an update event: the pop sees empty (underflow sets) and the pushed word stays in the FIFO.
  - fifo_level and s_ready update in the cycle after the push/pop.
  - Pushes are accepted in both modes.
- underflow: a set and a clr_underflow in the same cycle leave underflow=1 (set wins).
- Pointers wrap modulo DEPTH. Read-first ordering: data leaves in the order it was written.

Test Plan:
- Basic FIFO mode, div=3: push 0x11, 0x22, 0x33, then en=1. Required:
  - dac_data steps 0x11, 0x22, 0x33 every 4 clocks, with dac_strobe pulsing on each change.
  - dac_clk rises 2 cycles after each data change.
  - The 4th update holds 0x33 and sets underflow=1.
- Ramp with wrap: pattern_mode=1, div=1. dac_data must go 00, 01, ... FF, 00 every 2 clocks. fifo_level is unchanged and underflow stays 0.
- Backpressure, en=0: hold s_valid high with data 1..9. Required:
  - Exactly 8 accepted, then s_ready=0 and fifo_level=8.
  - Enabling with div=1 then drains 1..8 in order.
  - s_ready returns to 1 in the cycle after the first pop.
- div=0 and div=1 give identical waveforms (period 2). Changing div from 3 to 7 mid-period takes effect only after the current 4-cycle period completes.
- Underflow clear: with underflow=1, assert clr_underflow on an underflowing update cycle; underflow stays 1. Assert it on a non-update cycle; underflow drops to 0.
- Reset mid-stream: assert rst while the FIFO holds 5 entries and dac_clk=1. All outputs go to their reset values immediately; after release, fifo_level=0, s_ready=1, and the ramp restarts at 00.

Source files
------------

// File: rtl/dac_tx.sv
// dac_tx: FIFO-buffered parallel DAC transmitter with a programmable update
// period, a source-synchronous latch clock and a ramp pattern generator.
module dac_tx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DIV_W-1:0]       div,
  input  logic                   pattern_mode,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_W-1:0]      dac_data,
  output logic                   dac_clk,
  output logic                   dac_strobe,
  output logic                   underflow,
  input  logic                   clr_underflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // A divider setting of 0 behaves like 1 so the period never drops below 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v == '0) ? DIV_W'(1) : v;
  endfunction

  logic [DIV_W-1:0]  d_q;
  logic [DIV_W-1:0]  tick_cnt;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic wrap;
  logic update;
  logic half_pt;
  logic fifo_empty;
  logic push;
  logic pop;
  logic unf_set;

  assign wrap       = (tick_cnt == d_q);
  assign update     = en && wrap;
  assign half_pt    = en && (tick_cnt == (d_q >> 1));
  assign fifo_empty = (level == '0);
  assign s_ready    = (level != LW'(DEPTH));
  assign push       = s_valid && s_ready;
  // A word pushed on the same cycle as an update is not yet visible to the pop.
  assign pop        = update && !pattern_mode && !fifo_empty;
  assign unf_set    = update && !pattern_mode && fifo_empty;
  assign fifo_level = level;

  // Rate divider: the period length is only re-sampled at a wrap or while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q      <= DIV_W'(1);
      tick_cnt <= '0;
    end else begin
      if (!en || wrap) begin
        d_q      <= clamp_div(div);
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + DIV_W'(1);
      end
    end
  end

  // Output stage: data/strobe on update, latch clock rises mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data   <= '0;
      dac_clk    <= 1'b0;
      dac_strobe <= 1'b0;
      ramp       <= '0;
      underflow  <= 1'b0;
    end else begin
      dac_strobe <= update;
      if (!en || update) begin
        dac_clk <= 1'b0;
      end else if (half_pt) begin
        dac_clk <= 1'b1;
      end
      if (update) begin
        if (pattern_mode) begin
          dac_data <= ramp;
          ramp     <= ramp + DATA_W'(1);
        end else if (!fifo_empty) begin
          dac_data <= mem[rd_ptr];
        end
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_dac_tx.sv
// tb_dac_tx: randomized and directed stimulus for dac_tx, checked against a
// period-level reference model through an expected-update scoreboard.
module tb_dac_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [DIV_W-1:0]  div = 8'd3;
  logic              pattern_mode = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              clr_underflow = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] dac_data;
  logic              dac_clk;
  logic              dac_strobe;
  logic              underflow;
  logic [LW-1:0]     fifo_level;

  dac_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .pattern_mode(pattern_mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dac_data(dac_data), .dac_clk(dac_clk), .dac_strobe(dac_strobe),
    .underflow(underflow), .clr_underflow(clr_underflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: period length and position within the period.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_data_q[$];
  bit                exp_unf_q[$];
  int                per_m = 2;
  int                cyc_m = 0;
  int                pushes_m = 0;
  logic [DATA_W-1:0] ramp_m = '0;
  logic [DATA_W-1:0] data_m = '0;
  bit                unf_m = 1'b0;
  bit                clk_m = 1'b0;
  bit                strobe_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_data_q.delete();
    exp_unf_q.delete();
    per_m = 2; cyc_m = 0; ramp_m = '0; data_m = '0;
    unf_m = 1'b0; clk_m = 1'b0; strobe_m = 1'b0;
  endtask

  task automatic model_step();
    bit upd, ready, uset;
    ready = (mq.size() < DEPTH);
    upd   = en && (cyc_m == per_m - 1);
    uset  = 1'b0;
    strobe_m = upd;
    if (!en || upd) clk_m = 1'b0;
    else if (cyc_m == (per_m - 1) / 2) clk_m = 1'b1;
    if (upd) begin
      if (pattern_mode) begin
        data_m = ramp_m;
        ramp_m = ramp_m + 1'b1;
      end else if (mq.size() > 0) begin
        data_m = mq.pop_front();
      end else begin
        uset = 1'b1;
      end
    end
    if (s_valid && ready) begin
      mq.push_back(s_data);
      pushes_m++;
    end
    if (uset) unf_m = 1'b1;
    else if (clr_underflow) unf_m = 1'b0;
    if (upd) begin
      exp_data_q.push_back(data_m);
      exp_unf_q.push_back(unf_m);
    end
    if (!en || upd) begin
      cyc_m = 0;
      per_m = ((div == 0) ? 1 : int'(div)) + 1;
    end else begin
      cyc_m++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Monitor: compares continuous outputs and pops the scoreboard on each strobe.
  initial begin
    logic [DATA_W-1:0] e;
    bit u;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("dac_clk", dac_clk, clk_m);
        chk("dac_strobe", dac_strobe, strobe_m);
        chk("fifo_level", fifo_level, mq.size());
        chk("s_ready", s_ready, mq.size() < DEPTH);
        chk("underflow", underflow, unf_m);
        if (dac_strobe) begin
          checks++;
          if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL update_sb actual=strobe required=no_update at %0t", $time);
          end else begin
            e = exp_data_q.pop_front();
            u = exp_unf_q.pop_front();
            chk("update_data", dac_data, e);
            chk("update_underflow", underflow, u);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    cycles(1);
    s_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dac_data"}, dac_data, 0);
    chk({tag, "_dac_clk"}, dac_clk, 0);
    chk({tag, "_dac_strobe"}, dac_strobe, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_fifo_level"}, fifo_level, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
  endtask

  initial begin
    int p0, n;
    cycles(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    cycles(2);

    // Basic FIFO mode with div=3
    div = 8'd3;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    cycles(1);
    en = 1'b1;
    cycles(17);
    chk("fifo_hold_data", dac_data, 8'h33);
    chk("fifo_underflow_set", underflow, 1);

    // Clear attempted on an underflowing update cycle, then on a quiet cycle
    n = 0;
    while (cyc_m != per_m - 1 && n < 20) begin cycles(1); n++; end
    clr_underflow = 1'b1;
    cycles(1);
    clr_underflow = 1'b0;
    chk("clr_on_update_keeps", underflow, 1);
    n = 0;
    while (cyc_m != 0 && n < 20) begin cycles(1); n++; end
    clr_underflow = 1'b1;
    cycles(1);
    clr_underflow = 1'b0;
    chk("clr_on_quiet_clears", underflow, 0);
    cycles(3);

    // Ramp with wrap, FIFO holding two words that must stay put
    en = 1'b0;
    push_word(8'hA5);
    push_word(8'h5A);
    pattern_mode = 1'b1;
    div = 8'd1;
    clr_underflow = 1'b1;
    cycles(1);
    clr_underflow = 1'b0;
    en = 1'b1;
    cycles(2 * 260);
    chk("ramp_level_kept", fifo_level, 2);
    chk("ramp_no_underflow", underflow, 0);

    // Drain the leftovers, then backpressure with en=0
    pattern_mode = 1'b0;
    cycles(8);
    en = 1'b0;
    clr_underflow = 1'b1;
    cycles(1);
    clr_underflow = 1'b0;
    p0 = pushes_m;
    for (int i = 0; i < 14; i++) begin
      s_valid = (pushes_m - p0) < 9;
      s_data  = DATA_W'(pushes_m - p0 + 1);
      cycles(1);
    end
    s_valid = 1'b0;
    chk("bp_accepted", pushes_m - p0, 8);
    chk("bp_level_full", fifo_level, 8);
    chk("bp_not_ready", s_ready, 0);
    div = 8'd1;
    en = 1'b1;
    cycles(20);

    // div=0 behaves as div=1, then a mid-period change from 3 to 7
    en = 1'b0;
    div = 8'd0;
    pattern_mode = 1'b1;
    cycles(1);
    en = 1'b1;
    cycles(12);
    en = 1'b0;
    div = 8'd3;
    cycles(1);
    en = 1'b1;
    cycles(5);
    div = 8'd7;
    cycles(30);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s_valid = $urandom_range(0, 1);
      s_data  = DATA_W'($urandom);
      clr_underflow = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) div = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) pattern_mode = ~pattern_mode;
      cycles(1);
    end
    s_valid = 1'b0;
    clr_underflow = 1'b0;

    // Reset mid-stream with 5 entries queued and dac_clk high
    en = 1'b0;
    pattern_mode = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DATA_W'(8'hC0 + i));
    div = 8'd7;
    en = 1'b1;
    n = 0;
    while (!clk_m && n < 20) begin cycles(1); n++; end
    chk("pre_rst_level", fifo_level, 5);
    chk("pre_rst_dac_clk", dac_clk, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_ready", s_ready, 1);
    pattern_mode = 1'b1;
    div = 8'd1;
    en = 1'b1;
    cycles(3);
    chk("ramp_restart", dac_data, 8'h00);
    cycles(6);
    en = 1'b0;
    cycles(2);
    chk("scoreboard_drained", exp_data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
